// File: rtl/prm_edge_mask_accum.sv
// prm_edge_mask_accum: streams obstacle codes onto the checker bus and ORs edge masks into a frame bitmap.
// Define PRM_EDGE_FREE_CNT_EN to add a registered free-edge count (one extra cycle of result latency).
module prm_edge_mask_accum #(
  parameter int NUM_EDGES = 512,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic obs_valid,
  output logic obs_ready,
  input  logic [14:0] obs_code,
  input  logic obs_last,
  output logic [14:0] chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic res_valid,
  input  logic res_ready,
  output logic [NUM_EDGES-1:0] res_mask,
  output logic [CNT_W-1:0] res_count,
`ifdef PRM_EDGE_FREE_CNT_EN
  output logic [$clog2(NUM_EDGES+1)-1:0] free_cnt,
`endif
  output logic busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic s1_vld, s1_last, s2_last, fin, hs, fire;
  logic [NUM_EDGES-1:0] acc, acc_nx;
  assign fire = obs_valid && obs_ready;
  assign hs = state == DONE && res_ready;
  assign acc_nx = acc | chk_mask;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE && fire) ? ACCUM : (state == ACCUM && fin) ? DONE : hs ? IDLE : state;
  always_comb
    busy = state != IDLE;
  // chk_mask follows chk_code combinationally, so it is folded in one cycle after each accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      obs_ready <= 1'b0;
      chk_code <= '0;
      s1_vld <= 1'b0;
      s1_last <= 1'b0;
      s2_last <= 1'b0;
      acc <= '0;
      res_valid <= 1'b0;
      res_mask <= '0;
      res_count <= '0;
    end else begin
      obs_ready <= (fire && obs_last) ? 1'b0 : (hs || state == IDLE) ? 1'b1 : obs_ready;
      s1_vld <= fire;
      if (fire) begin
        chk_code <= obs_code;
        s1_last <= obs_last;
      end
      s2_last <= s1_vld && s1_last;
      acc <= hs ? '0 : s1_vld ? acc_nx : acc;
      if (s2_last) res_mask <= acc_nx;
      res_valid <= fin ? 1'b1 : hs ? 1'b0 : res_valid;
      res_count <= hs ? '0 : (fire && !(&res_count)) ? res_count + 1'b1 : res_count;
    end
`ifdef PRM_EDGE_FREE_CNT_EN
  localparam int FW = $clog2(NUM_EDGES + 1);
  logic s3_last;
  logic [FW-1:0] zeros;
  always_comb begin
    zeros = '0;
    for (int i = 0; i < NUM_EDGES; i++) zeros = zeros + FW'(~acc_nx[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s3_last <= 1'b0;
      free_cnt <= '0;
    end else begin
      s3_last <= s2_last;
      if (s2_last) free_cnt <= zeros;
    end
  assign fin = s3_last;
`else
  assign fin = s2_last;
`endif
endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// tb_prm_edge_mask_accum: random and directed frames checked against a frame-level scoreboard model.
module tb_prm_edge_mask_accum;
  localparam int NE = 8, CW = 3, MAXC = 7;
`ifdef PRM_EDGE_FREE_CNT_EN
  localparam int LAT = 3;
  logic [3:0] free_cnt;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst_n = 0, obs_valid = 0, obs_last = 0, res_ready = 0;
  logic obs_ready, res_valid, busy;
  logic [14:0] obs_code = 0, chk_code;
  logic [NE-1:0] chk_mask, res_mask;
  logic [CW-1:0] res_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign chk_mask = chk_code[7:0];
  prm_edge_mask_accum #(.NUM_EDGES(NE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_code(obs_code),
    .obs_last(obs_last), .chk_code(chk_code), .chk_mask(chk_mask), .res_valid(res_valid),
    .res_ready(res_ready), .res_mask(res_mask), .res_count(res_count),
`ifdef PRM_EDGE_FREE_CNT_EN
    .free_cnt(free_cnt),
`endif
    .busy(busy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // frame-level model: closed frames wait in a queue with the negedge index their result is due
  int n = 0, open_n = 0;
  logic [7:0] open_mask = 0;
  logic [7:0] q_mask[$];
  int q_cnt[$], q_due[$];
  bit fire_p = 0, fire_last = 0, hs_p = 0, warm = 0, ev;
  logic [14:0] fire_code = 0;
  always @(negedge clk) begin
    n++;
    if (!rst_n) begin
      chk("rst_ready", obs_ready, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_mask", res_mask, 0);
      chk("rst_count", res_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_code", chk_code, 0);
      q_mask.delete(); q_cnt.delete(); q_due.delete();
      open_n = 0; open_mask = 0; fire_p = 0; hs_p = 0; warm = 0;
    end else begin
      if (hs_p) begin
        void'(q_mask.pop_front()); void'(q_cnt.pop_front()); void'(q_due.pop_front());
      end
      if (fire_p) begin
        chk("chk_code", chk_code, fire_code);
        open_n++;
        open_mask |= fire_code[7:0];
        if (fire_last) begin
          q_mask.push_back(open_mask);
          q_cnt.push_back(open_n > MAXC ? MAXC : open_n);
          q_due.push_back(n + LAT);
          open_n = 0; open_mask = 0;
        end
      end
      ev = q_mask.size() != 0 && n >= q_due[0];
      chk("obs_ready", obs_ready, warm && q_mask.size() == 0);
      chk("busy", busy, open_n > 0 || q_mask.size() != 0);
      chk("res_valid", res_valid, ev);
      chk("res_count", res_count, q_mask.size() != 0 ? q_cnt[0] : (open_n > MAXC ? MAXC : open_n));
      if (ev) begin
        chk("res_mask", res_mask, q_mask[0]);
`ifdef PRM_EDGE_FREE_CNT_EN
        chk("free_cnt", free_cnt, NE - $countones(q_mask[0]));
`endif
      end
      warm = 1;
      fire_p = obs_valid && obs_ready;
      fire_code = obs_code;
      fire_last = obs_last;
      hs_p = res_valid && res_ready;
    end
  end

  task automatic send(input logic [14:0] c, input bit l);
    bit r, ok;
    ok = 0;
    obs_valid = 1; obs_code = c; obs_last = l;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); r = obs_ready;
      @(posedge clk); #1; ok = r;
    end
    chk("send_accept", ok, 1);
    if (l) begin obs_valid = 0; obs_last = 0; end
  endtask

  task automatic gap(input int k);
    obs_valid = 0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_res(input logic [7:0] m, input int c, input int hold, output int lat);
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (res_valid) lat = i;
    end
    chk("res_arrived", lat >= 0, 1);
    chk("lit_mask", res_mask, m);
    chk("lit_count", res_count, c);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      obs_valid = 1'($urandom_range(0, 1)); obs_code = 15'($urandom); obs_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_mask", res_mask, m);
      chk("hold_valid", res_valid, 1);
    end
    @(posedge clk); #1; obs_valid = 0; obs_last = 0; res_ready = 1;
    @(posedge clk); #1; res_ready = 0;
  endtask

  initial begin
    int lat, nb;
    logic [7:0] m;
    logic [14:0] c;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("ready_first_edge", obs_ready, 1);
    send(15'h0001, 0); send(15'h0010, 0); send(15'h0080, 1);
    wait_res(8'h91, 3, 0, lat);
    chk("latency", lat, LAT);
    send(15'h7F03, 1);
    wait_res(8'h03, 1, 5, lat);
    chk("ready_after_hs", obs_ready, 1);
    send(15'h0002, 0); gap(2); send(15'h0004, 1);
    wait_res(8'h06, 2, 0, lat);
    send(15'h0040, 0); send(15'h0020, 1);
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("no_result_after_abort", res_valid, 0);
    send(15'h0008, 1);
    wait_res(8'h08, 1, 0, lat);
`ifdef PRM_EDGE_FREE_CNT_EN
    send(15'h00F0, 1);
    wait_res(8'hF0, 1, 0, lat);
    chk("latency_free", lat, 3);
`endif
    for (int i = 0; i < 9; i++) begin
      c = 15'(1 << (i % 8));
      send(c, i == 8);
    end
    wait_res(8'hFF, 7, 1, lat);
    for (int f = 0; f < 40; f++) begin
      m = 0;
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        c = 15'($urandom);
        m |= c[7:0];
        send(c, b == nb - 1);
        if (b < nb - 1 && $urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end
      wait_res(m, nb > MAXC ? MAXC : nb, $urandom_range(0, 4), lat);
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
